// File: rtl/lcd_bus_responder.sv
// Display end of an HD44780-style parallel character-LCD bus: decodes command and
// data strobes into a 2x16 DDRAM mirror with address counter, busy timer and display state.
module lcd_bus_responder #(
    parameter int BUSY_CYCLES  = 40,
    parameter int CLEAR_CYCLES = 1600
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic [7:0] LCD_DATA,
    input  logic       LCD_RS,
    input  logic       LCD_RW,
    input  logic       LCD_EN,
    input  logic [4:0] iRD_ADDR,
    output logic [7:0] oRD_CHAR,
    output logic       oBUSY,
    output logic [4:0] oADDR,
    output logic       oDISPLAY_ON,
    output logic       oCMD_STROBE,
    output logic [7:0] oCMD,
    output logic       oCHAR_WE,
    output logic [7:0] oCHAR,
    output logic [7:0] oERR_CNT
);

    localparam int MAX_CYC = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] BUSY_LOAD  = CNT_W'(BUSY_CYCLES - 1);
    localparam logic [CNT_W-1:0] CLEAR_LOAD = CNT_W'(CLEAR_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    function automatic logic [4:0] step_addr(input logic [4:0] a, input logic up);
        logic [4:0] r;
        if (up) begin
            r = a + 5'd1;
        end else begin
            r = a - 5'd1;
        end
        return r;
    endfunction

    logic [10:0]      sync1_r;
    logic [10:0]      sync2_r;
    state_t           state_r;
    logic [CNT_W-1:0] count_r;
    logic             fill_r;
    logic [4:0]       fill_idx_r;
    logic             busy_r;
    logic [4:0]       addr_r;
    logic             inc_r;
    logic             disp_r;
    logic             cmd_strobe_r;
    logic [7:0]       cmd_r;
    logic             char_we_r;
    logic [7:0]       char_r;
    logic [7:0]       err_r;
    logic [7:0]       rd_char_r;
    logic [7:0]       mem_r [32];

    logic             fall_s;
    logic             rs_s;
    logic             rw_s;
    logic [7:0]       byte_s;
    logic             accept_s;
    logic             reject_s;
    logic             we_s;
    logic [4:0]       waddr_s;
    logic [7:0]       wdata_s;

    // Bus strobe and qualifiers resynchronised together into the iCLK domain.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            sync1_r <= 11'd0;
            sync2_r <= 11'd0;
        end else begin
            sync1_r <= {LCD_EN, LCD_RS, LCD_RW, LCD_DATA};
            sync2_r <= sync1_r;
        end
    end

    assign fall_s   = sync2_r[10] & ~sync1_r[10];
    assign rs_s     = sync2_r[9];
    assign rw_s     = sync2_r[8];
    assign byte_s   = sync2_r[7:0];
    assign accept_s = fall_s & ~rw_s & (state_r == ST_IDLE);
    assign reject_s = fall_s & ~accept_s;

    // DDRAM write port: clear fill has priority; character writes only occur in IDLE.
    always_comb begin
        we_s    = 1'b0;
        waddr_s = fill_idx_r;
        wdata_s = 8'h20;
        if ((state_r == ST_CLEAR) && fill_r) begin
            we_s = 1'b1;
        end else if (accept_s && rs_s) begin
            we_s    = 1'b1;
            waddr_s = addr_r;
            wdata_s = byte_s;
        end else begin
            we_s = 1'b0;
        end
    end

    // DDRAM storage; contents become defined through the fill that follows reset.
    always_ff @(posedge iCLK) begin
        if (we_s) begin
            mem_r[waddr_s] <= wdata_s;
        end
    end

    // Inspection port; sampled before any same-cycle write lands.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            rd_char_r <= 8'h00;
        end else begin
            rd_char_r <= mem_r[iRD_ADDR];
        end
    end

    // Control FSM, busy timer, instruction decode and error counter.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_r      <= ST_CLEAR;
            count_r      <= CLEAR_LOAD;
            fill_r       <= 1'b1;
            fill_idx_r   <= 5'd0;
            busy_r       <= 1'b0;
            addr_r       <= 5'd0;
            inc_r        <= 1'b1;
            disp_r       <= 1'b0;
            cmd_strobe_r <= 1'b0;
            cmd_r        <= 8'h00;
            char_we_r    <= 1'b0;
            char_r       <= 8'h00;
            err_r        <= 8'h00;
        end else begin
            cmd_strobe_r <= 1'b0;
            char_we_r    <= 1'b0;
            if (reject_s && (err_r != 8'hFF)) begin
                err_r <= err_r + 8'd1;
            end
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        busy_r  <= 1'b1;
                        state_r <= ST_BUSY;
                        count_r <= BUSY_LOAD;
                        if (rs_s) begin
                            char_we_r <= 1'b1;
                            char_r    <= byte_s;
                            addr_r    <= step_addr(addr_r, inc_r);
                        end else begin
                            cmd_strobe_r <= 1'b1;
                            cmd_r        <= byte_s;
                            // The highest set bit selects the instruction.
                            if (byte_s[7]) begin
                                addr_r <= {byte_s[6], byte_s[3:0]};
                            end else if (byte_s[6] | byte_s[5]) begin
                                addr_r <= addr_r;
                            end else if (byte_s[4]) begin
                                if (!byte_s[3]) begin
                                    addr_r <= step_addr(addr_r, byte_s[2]);
                                end
                            end else if (byte_s[3]) begin
                                disp_r <= byte_s[2];
                            end else if (byte_s[2]) begin
                                inc_r <= byte_s[1];
                            end else if (byte_s[1]) begin
                                addr_r  <= 5'd0;
                                state_r <= ST_CLEAR;
                                count_r <= CLEAR_LOAD;
                            end else if (byte_s[0]) begin
                                addr_r     <= 5'd0;
                                inc_r      <= 1'b1;
                                fill_r     <= 1'b1;
                                fill_idx_r <= 5'd0;
                                state_r    <= ST_CLEAR;
                                count_r    <= CLEAR_LOAD;
                            end else begin
                                addr_r <= addr_r;
                            end
                        end
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                ST_BUSY, ST_CLEAR: begin
                    if ((state_r == ST_CLEAR) && fill_r) begin
                        fill_idx_r <= fill_idx_r + 5'd1;
                        if (fill_idx_r == 5'd31) begin
                            fill_r <= 1'b0;
                        end
                    end
                    if (count_r == {CNT_W{1'b0}}) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
                        busy_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign oRD_CHAR    = rd_char_r;
    assign oBUSY       = busy_r;
    assign oADDR       = addr_r;
    assign oDISPLAY_ON = disp_r;
    assign oCMD_STROBE = cmd_strobe_r;
    assign oCMD        = cmd_r;
    assign oCHAR_WE    = char_we_r;
    assign oCHAR       = char_r;
    assign oERR_CNT    = err_r;

endmodule

// File: tb/tb_lcd_bus_responder.sv
// Randomised bench for lcd_bus_responder: a behavioural display model predicts strobes,
// DDRAM contents and status; a monitor pops expected strobes from a scoreboard queue.
module tb_lcd_bus_responder;

    localparam int BUSY_CYCLES  = 40;
    localparam int CLEAR_CYCLES = 1600;

    logic       iCLK = 1'b0;
    logic       iRST_N = 1'b0;
    logic [7:0] LCD_DATA = 8'h00;
    logic       LCD_RS = 1'b0;
    logic       LCD_RW = 1'b0;
    logic       LCD_EN = 1'b0;
    logic [4:0] iRD_ADDR = 5'd0;
    logic [7:0] oRD_CHAR;
    logic       oBUSY;
    logic [4:0] oADDR;
    logic       oDISPLAY_ON;
    logic       oCMD_STROBE;
    logic [7:0] oCMD;
    logic       oCHAR_WE;
    logic [7:0] oCHAR;
    logic [7:0] oERR_CNT;

    lcd_bus_responder #(.BUSY_CYCLES(BUSY_CYCLES), .CLEAR_CYCLES(CLEAR_CYCLES)) dut (
        .iCLK(iCLK), .iRST_N(iRST_N), .LCD_DATA(LCD_DATA), .LCD_RS(LCD_RS),
        .LCD_RW(LCD_RW), .LCD_EN(LCD_EN), .iRD_ADDR(iRD_ADDR), .oRD_CHAR(oRD_CHAR),
        .oBUSY(oBUSY), .oADDR(oADDR), .oDISPLAY_ON(oDISPLAY_ON), .oCMD_STROBE(oCMD_STROBE),
        .oCMD(oCMD), .oCHAR_WE(oCHAR_WE), .oCHAR(oCHAR), .oERR_CNT(oERR_CNT)
    );

    always #5 iCLK = ~iCLK;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural display model
    logic [7:0] m_ram [32];
    int         m_addr;
    bit         m_inc;
    bit         m_disp;
    int         m_err;
    int         m_cmd;
    int         m_char;

    typedef struct {
        bit         is_char;
        logic [7:0] val;
    } ev_t;
    ev_t exp_q[$];

    task automatic check(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    always @(negedge iCLK) begin : monitor
        ev_t ev;
        if (iRST_N) begin
            if (oCMD_STROBE) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_cmd_strobe", 1, 0);
                end else begin
                    ev = exp_q.pop_front();
                    check("strobe_kind_cmd", ev.is_char, 0);
                    check("cmd_byte", oCMD, ev.val);
                end
            end
            if (oCHAR_WE) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_char_we", 1, 0);
                end else begin
                    ev = exp_q.pop_front();
                    check("strobe_kind_char", ev.is_char, 1);
                    check("char_byte", oCHAR, ev.val);
                end
            end
        end
    end

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_ram[i] = 8'h20;
        m_addr = 0; m_inc = 1; m_disp = 0; m_err = 0; m_cmd = 0; m_char = 0;
        exp_q.delete();
    endtask

    task automatic model_cmd(input int c);
        ev_t ev;
        if (c == 1) begin
            for (int i = 0; i < 32; i++) m_ram[i] = 8'h20;
            m_addr = 0; m_inc = 1;
        end else if (c == 2 || c == 3) begin
            m_addr = 0;
        end else if (c >= 4 && c <= 7) begin
            m_inc = ((c / 2) % 2) == 1;
        end else if (c >= 8 && c <= 15) begin
            m_disp = ((c / 4) % 2) == 1;
        end else if (c >= 16 && c <= 31) begin
            if (((c / 8) % 2) == 0) m_addr = ((c / 4) % 2 == 1) ? (m_addr + 1) % 32 : (m_addr + 31) % 32;
        end else if (c >= 128) begin
            m_addr = ((c / 64) % 2) * 16 + (c % 16);
        end
        m_cmd = c;
        ev.is_char = 0; ev.val = 8'(c);
        exp_q.push_back(ev);
    endtask

    task automatic model_data(input int d);
        ev_t ev;
        m_ram[m_addr] = 8'(d);
        m_addr = m_inc ? (m_addr + 1) % 32 : (m_addr + 31) % 32;
        m_char = d;
        ev.is_char = 1; ev.val = 8'(d);
        exp_q.push_back(ev);
    endtask

    task automatic model_reject();
        if (m_err < 255) m_err++;
    endtask

    task automatic bus_strobe(input logic rs, input logic rw, input logic [7:0] d);
        @(negedge iCLK);
        LCD_RS = rs; LCD_RW = rw; LCD_DATA = d;
        repeat (2) @(negedge iCLK);
        LCD_EN = 1'b1;
        repeat (4) @(negedge iCLK);
        LCD_EN = 1'b0;
        repeat (4) @(negedge iCLK);
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (oBUSY && k < budget) begin
            @(negedge iCLK);
            k++;
        end
        check("busy_drop_within_budget", oBUSY, 0);
    endtask

    task automatic send_cmd(input int c);
        model_cmd(c);
        bus_strobe(1'b0, 1'b0, 8'(c));
        wait_idle(CLEAR_CYCLES + 40);
    endtask

    task automatic send_data(input int d);
        model_data(d);
        bus_strobe(1'b1, 1'b0, 8'(d));
        wait_idle(BUSY_CYCLES + 10);
    endtask

    task automatic check_state(input string tag);
        check({tag, "_addr"}, oADDR, m_addr);
        check({tag, "_display_on"}, oDISPLAY_ON, m_disp);
        check({tag, "_err_cnt"}, oERR_CNT, m_err);
        check({tag, "_last_cmd"}, oCMD, m_cmd);
        check({tag, "_last_char"}, oCHAR, m_char);
    endtask

    task automatic check_ram(input string tag);
        for (int i = 0; i < 32; i++) begin
            iRD_ADDR = 5'(i);
            @(negedge iCLK);
            check($sformatf("%s_ddram[%0d]", tag, i), oRD_CHAR, m_ram[i]);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check(tag, {oRD_CHAR, oBUSY, oADDR, oDISPLAY_ON, oCMD_STROBE, oCMD,
                    oCHAR_WE, oCHAR, oERR_CNT}, 0);
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1);
    end

    initial begin : stimulus
        int kind;
        int d;
        model_reset();
        repeat (3) @(negedge iCLK);
        check_outputs_zero("reset_outputs");
        iRST_N = 1'b1;
        repeat (2) @(negedge iCLK);
        check("t1_busy_during_fill", oBUSY, 1);
        wait_idle(32 + CLEAR_CYCLES + 4);
        check_ram("t1");
        check_state("t1");

        send_cmd(8'h0F);
        send_data(8'h41);
        check_state("t2");

        send_cmd(8'hCF);
        send_data(8'h42);
        send_data(8'h43);
        check_state("t3");
        check_ram("t3");

        send_cmd(8'h04);
        send_cmd(8'h80);
        send_data(8'h58);
        check_state("t4_dec");
        send_cmd(8'h14);
        check_state("t4_shift");
        send_cmd(8'h06);

        // Second strobe lands inside the busy window; third is a read cycle.
        model_data(8'h33);
        bus_strobe(1'b1, 1'b0, 8'h33);
        model_reject();
        bus_strobe(1'b1, 1'b0, 8'h44);
        wait_idle(BUSY_CYCLES + 10);
        model_reject();
        bus_strobe(1'b1, 1'b1, 8'h55);
        check_state("t5");
        check_ram("t5");

        for (int it = 0; it < 80; it++) begin
            kind = $urandom_range(0, 99);
            d = $urandom_range(32, 126);
            if (kind < 40) begin
                send_data(d);
            end else if (kind < 55) begin
                send_cmd($urandom_range(128, 255));
            end else if (kind < 62) begin
                send_cmd($urandom_range(4, 7));
            end else if (kind < 70) begin
                send_cmd($urandom_range(8, 15));
            end else if (kind < 80) begin
                send_cmd($urandom_range(16, 31));
            end else if (kind < 84) begin
                send_cmd($urandom_range(32, 127));
            end else if (kind < 86) begin
                send_cmd($urandom_range(2, 3));
            end else if (kind < 88) begin
                send_cmd(1);
            end else if (kind < 94) begin
                model_reject();
                bus_strobe(1'($urandom_range(0, 1)), 1'b1, 8'(d));
            end else begin
                model_data(d);
                bus_strobe(1'b1, 1'b0, 8'(d));
                model_reject();
                bus_strobe(1'b1, 1'b0, 8'($urandom_range(32, 126)));
                wait_idle(BUSY_CYCLES + 10);
            end
            check_state($sformatf("rand%0d", it));
            if (it % 20 == 19) check_ram($sformatf("rand%0d", it));
        end

        send_cmd(8'h06);
        send_cmd(8'hC4);
        for (int i = 0; i < 6; i++) send_data(8'h61 + i);
        check_ram("t6_pre");
        model_cmd(8'h01);
        bus_strobe(1'b0, 1'b0, 8'h01);
        repeat (5) @(negedge iCLK);
        #2;
        iRST_N = 1'b0;
        #1;
        check_outputs_zero("t6_reset_mid_fill");
        model_reset();
        repeat (2) @(negedge iCLK);
        iRST_N = 1'b1;
        repeat (2) @(negedge iCLK);
        check("t6_busy_after_release", oBUSY, 1);
        wait_idle(32 + CLEAR_CYCLES + 4);
        check_ram("t6");
        check_state("t6");

        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
